accel_mem_ctrl: RTL and testbench

Shared memory and MMIO controller sitting between the host bus and the matrix/maxpool accelerator. It is the responder for the accelerator's memory port (`MemAddr`/`MemEn`/`MemWrEn`/`MemWrData`/`MemRdData`). It forwards host start writes to the accelerator's MMIO inputs and tracks job completion through the flag registers. It owns the descriptor register window (dimensions, base pointers, flags) and a single-port data SRAM, and arbitrates between host and accelerator with fixed accelerator priority.

---
 rtl/accel_mem_pkg.sv | 35 +++
 rtl/accel_mem_sram.sv | 33 +++
 rtl/accel_mem_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_accel_mem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_mem_pkg.sv
// accel_mem_pkg: shared constants and types for the accelerator memory/MMIO
// controller.
//   - byte addresses of the descriptor and flag registers (0xA00..0xA1C)
//   - job_state_t, the job FSM state encoding
//   - job kind encoding (flag address bit 2 selects MATMUL/MAXPOOL)
package accel_mem_pkg;

  localparam logic [31:0] ADDR_MATDIMM = 32'h0000_0A00;
  localparam logic [31:0] ADDR_MATDIMN = 32'h0000_0A04;
  localparam logic [31:0] ADDR_MATDIMP = 32'h0000_0A08;
  localparam logic [31:0] ADDR_MATMULA = 32'h0000_0A0C;
  localparam logic [31:0] ADDR_MATMULB = 32'h0000_0A10;
  localparam logic [31:0] ADDR_MATMULC = 32'h0000_0A14;
  localparam logic [31:0] ADDR_MATMULF = 32'h0000_0A18;
  localparam logic [31:0] ADDR_MAXPOLF = 32'h0000_0A1C;

  // Number of plain descriptor registers (word offsets 0..5 in the window).
  localparam logic [2:0] NUM_DESC = 3'd6;

  localparam logic KIND_MATMUL  = 1'b0;
  localparam logic KIND_MAXPOOL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } job_state_t;

  // Flag register read image: {29'b0, err, done, busy}.
  function automatic logic [31:0] flag_word(input logic err, input logic done,
                                            input logic busy);
    return {29'b0, err, done, busy};
  endfunction

endpackage

// File: rtl/accel_mem_sram.sv
// accel_mem_sram: single-port synchronous RAM, DEPTH x 32, one-cycle read.
// Contents are not reset.
//   clk     in  clock
//   i_en    in  access enable
//   i_we    in  write enable (qualified by i_en)
//   i_addr  in  word address
//   i_wdata in  write data
//   o_rdata out read data, valid the cycle after a read access, held otherwise
module accel_mem_sram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/accel_mem_ctrl.sv
// accel_mem_ctrl: shared SRAM + descriptor/flag register controller between
// the host bus and the matrix/maxpool accelerator. Accelerator has fixed
// priority; the host is stalled when both request in the same cycle.
// Optional feature macro: ACCEL_MEM_IRQ_EN (level completion interrupt on Irq;
// when undefined Irq is tied 0).
//   clk, rst_n                       clock, async active-low reset
//   HostAddr/HostEn/HostWrEn/HostWrData  host request (byte address)
//   HostRdData                       host read data, 1-cycle latency, held
//   HostStall                        host request not accepted this cycle
//   MemAddr/MemEn/MemWrEn/MemWrData  accelerator request (byte address)
//   MemRdData                        accelerator read data, 1-cycle latency
//   MMIOAddr/MMIOEn/MMIOWrEn         one-cycle start strobe to accelerator
//   Irq                              completion interrupt
//
// state | meaning
// IDLE  | no job outstanding
// BUSY  | job started, waiting for accelerator completion write
// DONE  | job finished, waiting for host to clear with a 0 write
module accel_mem_ctrl #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] SRAM_BASE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] HostAddr,
  input  logic        HostEn,
  input  logic        HostWrEn,
  input  logic [31:0] HostWrData,
  output logic [31:0] HostRdData,
  output logic        HostStall,
  input  logic [31:0] MemAddr,
  input  logic        MemEn,
  input  logic        MemWrEn,
  input  logic [31:0] MemWrData,
  output logic [31:0] MemRdData,
  output logic [31:0] MMIOAddr,
  output logic        MMIOEn,
  output logic        MMIOWrEn,
  output logic        Irq
);
  import accel_mem_pkg::*;

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] SRAM_BYTES = 32'(4 * DEPTH);

  logic        w_host_acc;
  logic        w_h_win, w_m_win, w_h_sram, w_m_sram;
  logic [2:0]  w_h_idx, w_m_idx;
  logic [31:0] w_h_off, w_m_off;
  logic [31:0] w_h_reg_rd, w_m_reg_rd, w_flag_mm, w_flag_mp, w_sram_q;
  logic        w_h_flag_wr, w_m_flag_wr;

  assign HostStall  = HostEn & MemEn;
  assign w_host_acc = HostEn & ~MemEn;

  // Register window is the 32-byte block at 0xA00; word index 6/7 are flags.
  assign w_h_win  = (HostAddr[31:5] == ADDR_MATDIMM[31:5]);
  assign w_m_win  = (MemAddr[31:5]  == ADDR_MATDIMM[31:5]);
  assign w_h_idx  = HostAddr[4:2];
  assign w_m_idx  = MemAddr[4:2];
  // Unsigned offset: addresses below SRAM_BASE wrap high and miss.
  assign w_h_off  = HostAddr - SRAM_BASE;
  assign w_m_off  = MemAddr  - SRAM_BASE;
  assign w_h_sram = (w_h_off < SRAM_BYTES);
  assign w_m_sram = (w_m_off < SRAM_BYTES);

  assign w_h_flag_wr = w_host_acc & HostWrEn & w_h_win & (w_h_idx[2:1] == 2'b11);
  assign w_m_flag_wr = MemEn & MemWrEn & w_m_win & (w_m_idx[2:1] == 2'b11);

  // ---------------- descriptor registers ----------------
  logic [31:0] r_desc [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_desc[i] <= '0;
    end else if (MemEn & MemWrEn & w_m_win & (w_m_idx < NUM_DESC)) begin
      r_desc[w_m_idx] <= MemWrData;
    end else if (w_host_acc & HostWrEn & w_h_win & (w_h_idx < NUM_DESC)) begin
      r_desc[w_h_idx] <= HostWrData;
    end
  end

  // ---------------- job FSM ----------------
  job_state_t  r_state, w_state_nxt;
  logic        r_kind, w_kind_nxt;
  logic        r_err, w_err_nxt;
  logic        r_strobe, w_strobe_nxt;
  logic [31:0] r_mmio_addr, w_mmio_addr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_kind      <= KIND_MATMUL;
      r_err       <= 1'b0;
      r_strobe    <= 1'b0;
      r_mmio_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_kind      <= w_kind_nxt;
      r_err       <= w_err_nxt;
      r_strobe    <= w_strobe_nxt;
      r_mmio_addr <= w_mmio_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_kind_nxt      = r_kind;
    w_err_nxt       = r_err;
    w_strobe_nxt    = 1'b0;
    w_mmio_addr_nxt = r_mmio_addr;
    if (w_m_flag_wr) begin
      if ((MemWrData != '0) && (r_state == BUSY) && (w_m_idx[0] == r_kind))
        w_state_nxt = DONE;
    end else if (w_h_flag_wr) begin
      if (HostWrData != '0) begin
        if (r_state == BUSY) begin
          w_err_nxt = 1'b1;
        end else begin
          w_state_nxt     = BUSY;
          w_kind_nxt      = w_h_idx[0];
          w_strobe_nxt    = 1'b1;
          w_mmio_addr_nxt = {HostAddr[31:2], 2'b00};
        end
      end else if (r_state != BUSY) begin
        w_state_nxt = IDLE;
        w_err_nxt   = 1'b0;
      end
    end
  end

  assign MMIOAddr = r_mmio_addr;
  assign MMIOEn   = r_strobe;
  assign MMIOWrEn = r_strobe;

  assign w_flag_mm = flag_word(r_err, (r_state == DONE) && (r_kind == KIND_MATMUL),
                               (r_state == BUSY) && (r_kind == KIND_MATMUL));
  assign w_flag_mp = flag_word(r_err, (r_state == DONE) && (r_kind == KIND_MAXPOOL),
                               (r_state == BUSY) && (r_kind == KIND_MAXPOOL));

`ifdef ACCEL_MEM_IRQ_EN
  logic r_irq;
  logic w_done_evt, w_clr_evt;
  assign w_done_evt = (r_state == BUSY) && (w_state_nxt == DONE);
  assign w_clr_evt  = w_h_flag_wr && (HostWrData == '0) && (r_state != BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_irq <= 1'b0;
    else if (w_done_evt) r_irq <= 1'b1;
    else if (w_clr_evt)  r_irq <= 1'b0;
  end
  assign Irq = r_irq;
`else
  assign Irq = 1'b0;
`endif

  // ---------------- read paths ----------------
  always_comb begin
    w_h_reg_rd = '0;
    if (w_h_win) begin
      if (w_h_idx < NUM_DESC) w_h_reg_rd = r_desc[w_h_idx];
      else                    w_h_reg_rd = w_h_idx[0] ? w_flag_mp : w_flag_mm;
    end
  end

  always_comb begin
    w_m_reg_rd = '0;
    if (w_m_win) begin
      if (w_m_idx < NUM_DESC) w_m_reg_rd = r_desc[w_m_idx];
      else                    w_m_reg_rd = w_m_idx[0] ? w_flag_mp : w_flag_mm;
    end
  end

  // The SRAM output is shared by both ports and changes on the other port's
  // reads, so each port presents it for one cycle and then holds a copy.
  logic        r_h_src_sram, r_m_src_sram;
  logic [31:0] r_h_rd, r_m_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_src_sram <= 1'b0;
      r_h_rd       <= '0;
    end else begin
      if (r_h_src_sram) r_h_rd <= w_sram_q;
      r_h_src_sram <= 1'b0;
      if (w_host_acc & ~HostWrEn) begin
        r_h_src_sram <= w_h_sram;
        if (!w_h_sram) r_h_rd <= w_h_reg_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_src_sram <= 1'b0;
      r_m_rd       <= '0;
    end else begin
      if (r_m_src_sram) r_m_rd <= w_sram_q;
      r_m_src_sram <= 1'b0;
      if (MemEn & ~MemWrEn) begin
        r_m_src_sram <= w_m_sram;
        if (!w_m_sram) r_m_rd <= w_m_reg_rd;
      end
    end
  end

  assign HostRdData = r_h_src_sram ? w_sram_q : r_h_rd;
  assign MemRdData  = r_m_src_sram ? w_sram_q : r_m_rd;

  // ---------------- SRAM ----------------
  logic          w_sram_en, w_sram_we;
  logic [AW-1:0] w_sram_addr;
  logic [31:0]   w_sram_wdata;

  assign w_sram_en    = (MemEn & w_m_sram) | (w_host_acc & w_h_sram);
  assign w_sram_we    = MemEn ? MemWrEn : HostWrEn;
  assign w_sram_addr  = MemEn ? w_m_off[AW+1:2] : w_h_off[AW+1:2];
  assign w_sram_wdata = MemEn ? MemWrData : HostWrData;

  accel_mem_sram #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk     (clk),
    .i_en    (w_sram_en),
    .i_we    (w_sram_we),
    .i_addr  (w_sram_addr),
    .i_wdata (w_sram_wdata),
    .o_rdata (w_sram_q)
  );

endmodule

// File: tb/tb_accel_mem_ctrl.sv
module tb_accel_mem_ctrl;
  localparam int          DEPTH     = 1024;
  localparam logic [31:0] SRAM_BASE = 32'h0000_1000;
  localparam logic [31:0] SRAM_END  = SRAM_BASE + 32'(4 * DEPTH);
`ifdef ACCEL_MEM_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] HostAddr, HostWrData, HostRdData, MemAddr, MemWrData, MemRdData, MMIOAddr;
  logic        HostEn, HostWrEn, HostStall, MemEn, MemWrEn, MMIOEn, MMIOWrEn, Irq;

  int n_checks = 0;
  int n_pass   = 0;

  accel_mem_ctrl #(.DEPTH(DEPTH), .SRAM_BASE(SRAM_BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .HostAddr(HostAddr), .HostEn(HostEn), .HostWrEn(HostWrEn), .HostWrData(HostWrData),
    .HostRdData(HostRdData), .HostStall(HostStall),
    .MemAddr(MemAddr), .MemEn(MemEn), .MemWrEn(MemWrEn), .MemWrData(MemWrData),
    .MemRdData(MemRdData), .MMIOAddr(MMIOAddr), .MMIOEn(MMIOEn), .MMIOWrEn(MMIOWrEn),
    .Irq(Irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_desc [6];
  logic [31:0] m_sram [int];
  bit          m_running, m_finished, m_kind, m_err, m_irq;
  logic [31:0] e_host_rd, e_mem_rd, e_mmio_addr;
  bit          e_strobe;

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) m_desc[i] = '0;
    m_sram.delete();
    m_running = 0; m_finished = 0; m_kind = 0; m_err = 0; m_irq = 0;
    e_host_rd = '0; e_mem_rd = '0; e_mmio_addr = '0; e_strobe = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    bit k;
    w = {a[31:2], 2'b00};
    if (w >= 32'hA00 && w <= 32'hA14) return m_desc[int'((w - 32'hA00) >> 2)];
    if (w == 32'hA18 || w == 32'hA1C) begin
      k = (w == 32'hA1C);
      return {29'b0, m_err, m_finished && (m_kind == k), m_running && (m_kind == k)};
    end
    if (w >= SRAM_BASE && w < SRAM_END) begin
      if (m_sram.exists(int'((w - SRAM_BASE) >> 2))) return m_sram[int'((w - SRAM_BASE) >> 2)];
      return 32'hxxxx_xxxx;
    end
    return 32'h0;
  endfunction

  function automatic void m_write(input bit from_host, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    bit k;
    w = {a[31:2], 2'b00};
    if (w >= 32'hA00 && w <= 32'hA14) m_desc[int'((w - 32'hA00) >> 2)] = d;
    else if (w == 32'hA18 || w == 32'hA1C) begin
      k = (w == 32'hA1C);
      if (from_host) begin
        if (d != 0) begin
          if (m_running) m_err = 1;
          else begin
            m_running = 1; m_finished = 0; m_kind = k;
            e_strobe = 1; e_mmio_addr = w;
          end
        end else if (!m_running) begin
          m_finished = 0; m_err = 0; m_irq = 0;
        end
      end else if (d != 0 && m_running && m_kind == k) begin
        m_running = 0; m_finished = 1;
        if (IRQ_EN) m_irq = 1;
      end
    end else if (w >= SRAM_BASE && w < SRAM_END) begin
      m_sram[int'((w - SRAM_BASE) >> 2)] = d;
    end
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic drive(input bit he, input bit hw_, input logic [31:0] ha, input logic [31:0] hd,
                       input bit me, input bit mw_, input logic [31:0] ma, input logic [31:0] md);
    HostEn = he; HostWrEn = hw_; HostAddr = ha; HostWrData = hd;
    MemEn = me; MemWrEn = mw_; MemAddr = ma; MemWrData = md;
    #1;
  endtask

  // Advance one clock; the model applies the request that is on the bus now.
  task automatic tick();
    e_strobe = 0;
    if (MemEn) begin
      if (MemWrEn) m_write(0, MemAddr, MemWrData);
      else         e_mem_rd = m_read(MemAddr);
    end else if (HostEn) begin
      if (HostWrEn) m_write(1, HostAddr, HostWrData);
      else          e_host_rd = m_read(HostAddr);
    end
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic hw(input logic [31:0] a, input logic [31:0] d); drive(1, 1, a, d, 0, 0, 0, 0); tick(); endtask
  task automatic hr(input logic [31:0] a);                       drive(1, 0, a, 0, 0, 0, 0, 0); tick(); endtask
  task automatic mw(input logic [31:0] a, input logic [31:0] d); drive(0, 0, 0, 0, 1, 1, a, d); tick(); endtask
  task automatic mr(input logic [31:0] a);                       drive(0, 0, 0, 0, 1, 0, a, 0); tick(); endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    n_checks++; if (HostRdData !== 32'h0) $display("FAIL reset_host_rd: got %h want 0", HostRdData); else n_pass++;
    n_checks++; if (MemRdData !== 32'h0)  $display("FAIL reset_mem_rd: got %h want 0", MemRdData); else n_pass++;
    n_checks++; if (HostStall !== 1'b0)   $display("FAIL reset_stall: got %b want 0", HostStall); else n_pass++;
    n_checks++; if (MMIOAddr !== 32'h0)   $display("FAIL reset_mmio_addr: got %h want 0", MMIOAddr); else n_pass++;
    n_checks++; if (MMIOEn !== 1'b0)      $display("FAIL reset_mmio_en: got %b want 0", MMIOEn); else n_pass++;
    n_checks++; if (MMIOWrEn !== 1'b0)    $display("FAIL reset_mmio_wren: got %b want 0", MMIOWrEn); else n_pass++;
    n_checks++; if (Irq !== 1'b0)         $display("FAIL reset_irq: got %b want 0", Irq); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_regs_and_stall();
    hw(32'hA00, 32'd4);
    hr(32'hA00);
    n_checks++; if (HostRdData !== 32'd4) $display("FAIL host_rd_a00: got %h want 4", HostRdData); else n_pass++;
    mr(32'hA00);
    n_checks++; if (MemRdData !== 32'd4) $display("FAIL mem_rd_a00: got %h want 4", MemRdData); else n_pass++;
    hr(32'hA01);
    n_checks++; if (HostRdData !== 32'd4) $display("FAIL low_bits_ignored: got %h want 4", HostRdData); else n_pass++;
    hw(32'hA04, 32'd7);
    // contention: host held for one extra cycle, accelerator served
    drive(1, 0, 32'hA04, 0, 1, 0, 32'hA00, 0);
    n_checks++; if (HostStall !== 1'b1) $display("FAIL stall_both: got %b want 1", HostStall); else n_pass++;
    tick();
    n_checks++; if (MemRdData !== 32'd4)  $display("FAIL stall_mem_rd: got %h want 4", MemRdData); else n_pass++;
    n_checks++; if (HostRdData !== 32'd4) $display("FAIL stall_host_held: got %h want 4", HostRdData); else n_pass++;
    drive(1, 0, 32'hA04, 0, 0, 0, 0, 0);
    n_checks++; if (HostStall !== 1'b0) $display("FAIL stall_release: got %b want 0", HostStall); else n_pass++;
    tick();
    n_checks++; if (HostRdData !== 32'd7) $display("FAIL stall_host_done: got %h want 7", HostRdData); else n_pass++;
    // stalled host write must not land
    drive(1, 1, 32'hA08, 32'h99, 1, 1, 32'hA08, 32'h55);
    tick();
    mr(32'hA08);
    n_checks++; if (MemRdData !== 32'h55) $display("FAIL stalled_write_dropped: got %h want 55", MemRdData); else n_pass++;
  endtask

  task automatic test_job_fsm();
    hw(32'hA18, 32'd1);
    n_checks++; if (MMIOEn !== 1'b1 || MMIOWrEn !== 1'b1) $display("FAIL strobe_on: got %b%b want 11", MMIOEn, MMIOWrEn); else n_pass++;
    n_checks++; if (MMIOAddr !== 32'hA18) $display("FAIL strobe_addr: got %h want a18", MMIOAddr); else n_pass++;
    hr(32'hA18);
    n_checks++; if (MMIOEn !== 1'b0) $display("FAIL strobe_one_cycle: got %b want 0", MMIOEn); else n_pass++;
    n_checks++; if (HostRdData !== 32'h1) $display("FAIL flag_busy: got %h want 1", HostRdData); else n_pass++;
    mw(32'hA1C, 32'd1);
    hr(32'hA18);
    n_checks++; if (HostRdData !== 32'h1) $display("FAIL wrong_flag_ignored: got %h want 1", HostRdData); else n_pass++;
    mw(32'hA18, 32'd1);
    n_checks++; if (Irq !== IRQ_EN) $display("FAIL irq_done: got %b want %b", Irq, IRQ_EN); else n_pass++;
    mr(32'hA18);
    n_checks++; if (MemRdData !== 32'h2) $display("FAIL flag_done: got %h want 2", MemRdData); else n_pass++;
    hw(32'hA18, 32'd0);
    n_checks++; if (Irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", Irq); else n_pass++;
    hr(32'hA18);
    n_checks++; if (HostRdData !== 32'h0) $display("FAIL flag_idle: got %h want 0", HostRdData); else n_pass++;
    // error path
    hw(32'hA18, 32'd1);
    hw(32'hA1C, 32'd1);
    n_checks++; if (MMIOEn !== 1'b0) $display("FAIL busy_no_strobe: got %b want 0", MMIOEn); else n_pass++;
    hr(32'hA18);
    n_checks++; if (HostRdData !== 32'h5) $display("FAIL flag_err_busy: got %h want 5", HostRdData); else n_pass++;
    hr(32'hA1C);
    n_checks++; if (HostRdData !== 32'h4) $display("FAIL other_flag_err: got %h want 4", HostRdData); else n_pass++;
    hw(32'hA18, 32'd0);
    hr(32'hA18);
    n_checks++; if (HostRdData !== 32'h5) $display("FAIL zero_in_busy: got %h want 5", HostRdData); else n_pass++;
    mw(32'hA18, 32'd1);
    hr(32'hA18);
    n_checks++; if (HostRdData !== 32'h6) $display("FAIL flag_done_err: got %h want 6", HostRdData); else n_pass++;
    hw(32'hA18, 32'd0);
    hr(32'hA18);
    n_checks++; if (HostRdData !== 32'h0) $display("FAIL err_cleared: got %h want 0", HostRdData); else n_pass++;
  endtask

  task automatic test_sram();
    mw(SRAM_BASE + 32'd8, 32'hCAFE);
    hr(SRAM_BASE + 32'd8);
    n_checks++; if (HostRdData !== 32'hCAFE) $display("FAIL sram_cafe: got %h want cafe", HostRdData); else n_pass++;
    hr(32'h500);
    n_checks++; if (HostRdData !== 32'h0) $display("FAIL unmapped_rd: got %h want 0", HostRdData); else n_pass++;
    hw(SRAM_END - 32'd4, 32'h1111_2222);
    mr(SRAM_END - 32'd4);
    n_checks++; if (MemRdData !== 32'h1111_2222) $display("FAIL sram_last: got %h want 11112222", MemRdData); else n_pass++;
    hw(SRAM_BASE, 32'h5A5A);
    hw(SRAM_END, 32'hDEAD);
    hr(SRAM_END);
    n_checks++; if (HostRdData !== 32'h0) $display("FAIL sram_past_end: got %h want 0", HostRdData); else n_pass++;
    hr(SRAM_BASE);
    n_checks++; if (HostRdData !== 32'h5A5A) $display("FAIL sram_no_alias: got %h want 5a5a", HostRdData); else n_pass++;
    mr(SRAM_BASE + 32'd8);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    n_checks++; if (HostRdData !== 32'h5A5A) $display("FAIL host_rd_hold: got %h want 5a5a", HostRdData); else n_pass++;
    n_checks++; if (MemRdData !== 32'hCAFE) $display("FAIL mem_rd_hold: got %h want cafe", MemRdData); else n_pass++;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0:       a = 32'hA00 + 32'(4 * $urandom_range(0, 5));
      1:       a = ($urandom_range(0, 1) != 0) ? 32'hA1C : 32'hA18;
      2, 3:    a = SRAM_BASE + 32'(4 * $urandom_range(0, 15));
      default: case ($urandom_range(0, 3))
                 0: a = 32'h500;
                 1: a = SRAM_END;
                 2: a = 32'hA20;
                 default: a = SRAM_BASE - 32'd4;
               endcase
    endcase
    return a | 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    bit he, hwe, me, mwe;
    logic [31:0] ha, hd, ma, md;
    for (int i = 0; i < 16; i++) hw(SRAM_BASE + 32'(4 * i), $urandom);
    for (int c = 0; c < 400; c++) begin
      he = ($urandom_range(0, 1) != 0); hwe = ($urandom_range(0, 1) != 0);
      me = ($urandom_range(0, 2) == 0); mwe = ($urandom_range(0, 1) != 0);
      ha = rand_addr(); hd = rand_data(); ma = rand_addr(); md = rand_data();
      drive(he, hwe, ha, hd, me, mwe, ma, md);
      n_checks++; if (HostStall !== (he && me)) $display("FAIL rnd_stall c=%0d: got %b want %b", c, HostStall, he && me); else n_pass++;
      tick();
      n_checks++; if (HostRdData !== e_host_rd) $display("FAIL rnd_host_rd c=%0d: got %h want %h", c, HostRdData, e_host_rd); else n_pass++;
      n_checks++; if (MemRdData !== e_mem_rd) $display("FAIL rnd_mem_rd c=%0d: got %h want %h", c, MemRdData, e_mem_rd); else n_pass++;
      n_checks++; if (MMIOEn !== e_strobe || MMIOWrEn !== e_strobe) $display("FAIL rnd_strobe c=%0d: got %b%b want %b", c, MMIOEn, MMIOWrEn, e_strobe); else n_pass++;
      if (e_strobe) begin
        n_checks++; if (MMIOAddr !== e_mmio_addr) $display("FAIL rnd_mmio_addr c=%0d: got %h want %h", c, MMIOAddr, e_mmio_addr); else n_pass++;
      end
      n_checks++; if (Irq !== m_irq) $display("FAIL rnd_irq c=%0d: got %b want %b", c, Irq, m_irq); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_busy();
    hw(32'hA18, 32'd0);
    hw(32'hA0C, 32'h1234);
    hw(32'hA1C, 32'd1);
    mw(32'hA1C, 32'd1);
    hw(32'hA1C, 32'd1);
    n_checks++; if (Irq !== IRQ_EN) $display("FAIL irq_held_restart: got %b want %b", Irq, IRQ_EN); else n_pass++;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (MMIOEn !== 1'b0 || MMIOWrEn !== 1'b0) $display("FAIL rst_busy_strobe: got %b%b want 00", MMIOEn, MMIOWrEn); else n_pass++;
    n_checks++; if (MMIOAddr !== 32'h0) $display("FAIL rst_busy_mmio_addr: got %h want 0", MMIOAddr); else n_pass++;
    n_checks++; if (Irq !== 1'b0) $display("FAIL rst_busy_irq: got %b want 0", Irq); else n_pass++;
    n_checks++; if (HostRdData !== 32'h0 || MemRdData !== 32'h0) $display("FAIL rst_busy_rd: got %h/%h want 0/0", HostRdData, MemRdData); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    hr(32'hA1C);
    n_checks++; if (HostRdData !== 32'h0) $display("FAIL rst_flag_idle: got %h want 0", HostRdData); else n_pass++;
    mr(32'hA0C);
    n_checks++; if (MemRdData !== 32'h0) $display("FAIL rst_desc_clear: got %h want 0", MemRdData); else n_pass++;
    hw(32'hA18, 32'd1);
    n_checks++; if (MMIOEn !== 1'b1 || MMIOAddr !== 32'hA18) $display("FAIL rst_restart: got %b/%h want 1/a18", MMIOEn, MMIOAddr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_regs_and_stall();
    test_job_fsm();
    test_sram();
    test_random();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
